// File: rtl/spu32_sram_pkg.sv
// Shared definitions for the SRAM arbiter and the bus memory units that
// talk to it.
//   TAG_WIDTH       width of the request/ack tag carried by every port
//   TAG_MORE_BIT    tag bit that marks "more words follow" (grant is held)
//   ACCESS_CNT_BITS width of the per-word access counter (ACCESS_CYCLES <= 15)
//   sram_state_t    arbiter sequencing states
package spu32_sram_pkg;

    localparam int TAG_WIDTH       = 4;
    localparam int TAG_MORE_BIT    = 3;
    localparam int ACCESS_CNT_BITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } sram_state_t;

endpackage

// File: rtl/spu32_sram_phy.sv
// Pin sequencer for one word access on an external asynchronous 16-bit SRAM.
// A one-cycle start pulse begins an access of ACCESS_CYCLES cycles using the
// latched request fields; done is high in the last access cycle, and the read
// register captures the SRAM data on the edge that ends the access.
// Ports:
//   I_clk, I_reset_n           clock, asynchronous active-low reset
//   I_start                    begin an access on the next cycle
//   I_addr/I_data/I_we/I_ub/I_lb  latched access fields (held by the arbiter)
//   O_done                     last cycle of the access
//   O_data                     read register
//   O_sram_*, I_sram_din       SRAM pins (strobes active low)
module spu32_sram_phy
    import spu32_sram_pkg::*;
#(
    parameter int SRAM_ADDR_BITS = 18,
    parameter int ACCESS_CYCLES  = 2
) (
    input  logic                      I_clk,
    input  logic                      I_reset_n,
    input  logic                      I_start,
    input  logic [SRAM_ADDR_BITS-1:0] I_addr,
    input  logic [15:0]               I_data,
    input  logic                      I_we,
    input  logic                      I_ub,
    input  logic                      I_lb,
    output logic                      O_done,
    output logic [15:0]               O_data,
    output logic [SRAM_ADDR_BITS-1:0] O_sram_addr,
    output logic [15:0]               O_sram_dout,
    output logic                      O_sram_dout_en,
    input  logic [15:0]               I_sram_din,
    output logic                      O_sram_ce_n,
    output logic                      O_sram_oe_n,
    output logic                      O_sram_we_n,
    output logic                      O_sram_ub_n,
    output logic                      O_sram_lb_n
);

    localparam logic [ACCESS_CNT_BITS-1:0] LAST_CNT = ACCESS_CNT_BITS'(ACCESS_CYCLES - 1);

    logic                       busy;
    logic [ACCESS_CNT_BITS-1:0] cnt;
    logic                       last;

    assign last = (cnt == LAST_CNT);

    // Access counter and read capture. The counter runs 0..ACCESS_CYCLES-1
    // while busy; read data is sampled on the edge that leaves the last cycle,
    // when the SRAM output has been valid for the whole access.
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            busy   <= 1'b0;
            cnt    <= '0;
            O_data <= '0;
        end else if (I_start) begin
            busy <= 1'b1;
            cnt  <= '0;
        end else if (busy) begin
            if (last) begin
                busy   <= 1'b0;
                cnt    <= '0;
                O_data <= I_sram_din;
            end else begin
                cnt <= cnt + ACCESS_CNT_BITS'(1);
            end
        end
    end

    // Strobes are decoded straight from the registered busy flag so an
    // asynchronous reset releases the bus immediately. WE is released one
    // cycle early so data is held past the WE rising edge.
    assign O_done         = busy & last;
    assign O_sram_ce_n    = ~busy;
    assign O_sram_oe_n    = ~(busy & ~I_we);
    assign O_sram_we_n    = ~(busy & I_we & ~last);
    assign O_sram_ub_n    = ~(busy & I_ub);
    assign O_sram_lb_n    = ~(busy & I_lb);
    assign O_sram_dout_en = busy & I_we;
    assign O_sram_addr    = I_addr;
    assign O_sram_dout    = I_data;

endmodule

// File: rtl/spu32_sram_arbiter.sv
// Two-port arbiter for one external 16-bit asynchronous SRAM.
// Port 0 is the CPU memory bus unit, port 1 the video/DMA fetcher. A request
// tag of zero means idle; tag bit TAG_MORE_BIT keeps the grant (lock) on the
// same port so multi-word accesses run atomically. Each word runs IDLE ->
// ACCESS (ACCESS_CYCLES) -> ACK, and the tag is echoed back in the ACK cycle.
// Ports:
//   I_clk, I_reset_n                clock, asynchronous active-low reset
//   I_pN_request/addr/data/we/ub/lb port N request (N = 0, 1)
//   O_pN_ack, O_pN_stall            port N echoed tag and stall
//   O_data                          read data, valid in the ack cycle
//   O_sram_*, I_sram_din            SRAM pins (strobes active low)
module spu32_sram_arbiter
    import spu32_sram_pkg::*;
#(
    parameter int SRAM_ADDR_BITS = 18,
    parameter int ACCESS_CYCLES  = 2
) (
    input  logic                      I_clk,
    input  logic                      I_reset_n,
    input  logic [TAG_WIDTH-1:0]      I_p0_request,
    input  logic [SRAM_ADDR_BITS-1:0] I_p0_addr,
    input  logic [15:0]               I_p0_data,
    input  logic                      I_p0_we,
    input  logic                      I_p0_ub,
    input  logic                      I_p0_lb,
    output logic [TAG_WIDTH-1:0]      O_p0_ack,
    output logic                      O_p0_stall,
    input  logic [TAG_WIDTH-1:0]      I_p1_request,
    input  logic [SRAM_ADDR_BITS-1:0] I_p1_addr,
    input  logic [15:0]               I_p1_data,
    input  logic                      I_p1_we,
    input  logic                      I_p1_ub,
    input  logic                      I_p1_lb,
    output logic [TAG_WIDTH-1:0]      O_p1_ack,
    output logic                      O_p1_stall,
    output logic [15:0]               O_data,
    output logic [SRAM_ADDR_BITS-1:0] O_sram_addr,
    output logic [15:0]               O_sram_dout,
    output logic                      O_sram_dout_en,
    input  logic [15:0]               I_sram_din,
    output logic                      O_sram_ce_n,
    output logic                      O_sram_oe_n,
    output logic                      O_sram_we_n,
    output logic                      O_sram_ub_n,
    output logic                      O_sram_lb_n
);

    sram_state_t state_q, state_d;

    logic grant, grant_port, lock_release;
    logic gport_q, lock_q, lock_port_q, prio_q;
    logic phy_done, ack_cycle;

    logic [TAG_WIDTH-1:0]      acc_tag_q;
    logic [SRAM_ADDR_BITS-1:0] acc_addr_q;
    logic [15:0]               acc_data_q;
    logic                      acc_we_q, acc_ub_q, acc_lb_q;

    logic [TAG_WIDTH-1:0] req_prio, req_other, req_locked;

    assign req_prio   = prio_q      ? I_p1_request : I_p0_request;
    assign req_other  = prio_q      ? I_p0_request : I_p1_request;
    assign req_locked = lock_port_q ? I_p1_request : I_p0_request;

    // State register.
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and grant decision. While locked only the locked port may
    // be granted; if it goes idle the lock is dropped in that cycle without a
    // grant, so the other port wins on the following IDLE cycle.
    always_comb begin
        state_d      = state_q;
        grant        = 1'b0;
        grant_port   = prio_q;
        lock_release = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (lock_q) begin
                    if (req_locked != '0) begin
                        grant      = 1'b1;
                        grant_port = lock_port_q;
                    end else begin
                        lock_release = 1'b1;
                    end
                end else if (req_prio != '0) begin
                    grant      = 1'b1;
                    grant_port = prio_q;
                end else if (req_other != '0) begin
                    grant      = 1'b1;
                    grant_port = ~prio_q;
                end
                if (grant) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (phy_done) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Access registers, lock and priority. Fields are latched at grant so the
    // pins stay stable even if the requester changes after its ack. At ACK a
    // "more" tag locks the bus to this port; otherwise priority rotates.
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            gport_q     <= 1'b0;
            lock_q      <= 1'b0;
            lock_port_q <= 1'b0;
            prio_q      <= 1'b0;
            acc_tag_q   <= '0;
            acc_addr_q  <= '0;
            acc_data_q  <= '0;
            acc_we_q    <= 1'b0;
            acc_ub_q    <= 1'b0;
            acc_lb_q    <= 1'b0;
        end else begin
            if (grant) begin
                gport_q <= grant_port;
                if (grant_port) begin
                    acc_tag_q  <= I_p1_request;
                    acc_addr_q <= I_p1_addr;
                    acc_data_q <= I_p1_data;
                    acc_we_q   <= I_p1_we;
                    acc_ub_q   <= I_p1_ub;
                    acc_lb_q   <= I_p1_lb;
                end else begin
                    acc_tag_q  <= I_p0_request;
                    acc_addr_q <= I_p0_addr;
                    acc_data_q <= I_p0_data;
                    acc_we_q   <= I_p0_we;
                    acc_ub_q   <= I_p0_ub;
                    acc_lb_q   <= I_p0_lb;
                end
            end
            if (lock_release) begin
                lock_q <= 1'b0;
            end
            if (state_q == ST_ACK) begin
                if (acc_tag_q[TAG_MORE_BIT]) begin
                    lock_q      <= 1'b1;
                    lock_port_q <= gport_q;
                end else begin
                    lock_q <= 1'b0;
                    prio_q <= ~gport_q;
                end
            end
        end
    end

    // Ack and stall. Stall is also forced low while reset is asserted so a
    // requester never sees a stall from a bus that is being reset.
    assign ack_cycle  = (state_q == ST_ACK);
    assign O_p0_ack   = (ack_cycle && !gport_q) ? acc_tag_q : '0;
    assign O_p1_ack   = (ack_cycle &&  gport_q) ? acc_tag_q : '0;
    assign O_p0_stall = I_reset_n & (I_p0_request != '0) & ~(ack_cycle & ~gport_q);
    assign O_p1_stall = I_reset_n & (I_p1_request != '0) & ~(ack_cycle &  gport_q);

    spu32_sram_phy #(
        .SRAM_ADDR_BITS (SRAM_ADDR_BITS),
        .ACCESS_CYCLES  (ACCESS_CYCLES)
    ) u_phy (
        .I_clk          (I_clk),
        .I_reset_n      (I_reset_n),
        .I_start        (grant),
        .I_addr         (acc_addr_q),
        .I_data         (acc_data_q),
        .I_we           (acc_we_q),
        .I_ub           (acc_ub_q),
        .I_lb           (acc_lb_q),
        .O_done         (phy_done),
        .O_data         (O_data),
        .O_sram_addr    (O_sram_addr),
        .O_sram_dout    (O_sram_dout),
        .O_sram_dout_en (O_sram_dout_en),
        .I_sram_din     (I_sram_din),
        .O_sram_ce_n    (O_sram_ce_n),
        .O_sram_oe_n    (O_sram_oe_n),
        .O_sram_we_n    (O_sram_we_n),
        .O_sram_ub_n    (O_sram_ub_n),
        .O_sram_lb_n    (O_sram_lb_n)
    );

endmodule

// File: tb/tb_spu32_sram_arbiter.sv
// Testbench for spu32_sram_arbiter: directed scenarios plus random single-word
// traffic. An SRAM device model sits on the pins; a word-level shadow memory
// predicts read data and the expected pin/ack timing comes from the access
// rules (ACC access cycles, ack one cycle later).
module tb_spu32_sram_arbiter;

    localparam int AB  = 18;
    localparam int ACC = 2;
    localparam logic [5:0] IDLE_PINS = 6'b111110;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [3:0]    p0_request, p1_request, p0_ack, p1_ack;
    logic [AB-1:0] p0_addr, p1_addr, sram_addr;
    logic [15:0]   p0_data, p1_data, data, sram_dout, sram_din;
    logic          p0_we, p0_ub, p0_lb, p1_we, p1_ub, p1_lb;
    logic          p0_stall, p1_stall, dout_en;
    logic          ce_n, oe_n, we_n, ub_n, lb_n;

    int vectors;
    int miscompares;
    int n;
    int expect_port;

    logic [3:0]    cur_tag  [2];
    logic [AB-1:0] cur_addr [2];
    logic [15:0]   cur_data [2];
    logic          cur_we   [2];
    logic          cur_ub   [2];
    logic          cur_lb   [2];

    logic [15:0]   ref_mem [0:(1<<AB)-1];
    logic [15:0]   sram_mem [0:(1<<AB)-1];
    logic          preload_en;
    logic [AB-1:0] preload_addr;
    logic [15:0]   preload_data;

    always #5 clk = ~clk;

    spu32_sram_arbiter #(
        .SRAM_ADDR_BITS (AB),
        .ACCESS_CYCLES  (ACC)
    ) dut (
        .I_clk          (clk),
        .I_reset_n      (reset_n),
        .I_p0_request   (p0_request),
        .I_p0_addr      (p0_addr),
        .I_p0_data      (p0_data),
        .I_p0_we        (p0_we),
        .I_p0_ub        (p0_ub),
        .I_p0_lb        (p0_lb),
        .O_p0_ack       (p0_ack),
        .O_p0_stall     (p0_stall),
        .I_p1_request   (p1_request),
        .I_p1_addr      (p1_addr),
        .I_p1_data      (p1_data),
        .I_p1_we        (p1_we),
        .I_p1_ub        (p1_ub),
        .I_p1_lb        (p1_lb),
        .O_p1_ack       (p1_ack),
        .O_p1_stall     (p1_stall),
        .O_data         (data),
        .O_sram_addr    (sram_addr),
        .O_sram_dout    (sram_dout),
        .O_sram_dout_en (dout_en),
        .I_sram_din     (sram_din),
        .O_sram_ce_n    (ce_n),
        .O_sram_oe_n    (oe_n),
        .O_sram_we_n    (we_n),
        .O_sram_ub_n    (ub_n),
        .O_sram_lb_n    (lb_n)
    );

    // SRAM device model: asynchronous read, byte-lane writes sampled mid-cycle
    // while CE and WE are low. The preload path fills it during reset.
    assign sram_din = sram_mem[sram_addr];

    always @(negedge clk) begin
        if (preload_en) begin
            sram_mem[preload_addr] <= preload_data;
        end else if (!ce_n && !we_n) begin
            if (!ub_n) sram_mem[sram_addr][15:8] <= sram_dout[15:8];
            if (!lb_n) sram_mem[sram_addr][7:0]  <= sram_dout[7:0];
        end
    end

    // Global time limit so a stuck design still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    function automatic logic [3:0] ackOf(input int p);
        return (p == 0) ? p0_ack : p1_ack;
    endfunction

    function automatic logic stallOf(input int p);
        return (p == 0) ? p0_stall : p1_stall;
    endfunction

    function automatic logic [3:0] reqOf(input int p);
        return (p == 0) ? p0_request : p1_request;
    endfunction

    function automatic logic [5:0] pins();
        return {ce_n, oe_n, we_n, ub_n, lb_n, dout_en};
    endfunction

    // Expected strobes in access cycle k (1..ACC) of port p's current request.
    function automatic logic [5:0] accessPins(input int p, input int k);
        logic we_low;
        we_low = cur_we[p] && (k < ACC);
        return {1'b0, cur_we[p], !we_low, !cur_ub[p], !cur_lb[p], cur_we[p]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input int p, input logic [3:0] tag, input logic [AB-1:0] addr,
                                 input logic [15:0] wdata, input logic we, input logic ub, input logic lb);
        cur_tag[p]  = tag;
        cur_addr[p] = addr;
        cur_data[p] = wdata;
        cur_we[p]   = we;
        cur_ub[p]   = ub;
        cur_lb[p]   = lb;
        if (p == 0) begin
            p0_request = tag; p0_addr = addr; p0_data = wdata;
            p0_we = we; p0_ub = ub; p0_lb = lb;
        end else begin
            p1_request = tag; p1_addr = addr; p1_data = wdata;
            p1_we = we; p1_ub = ub; p1_lb = lb;
        end
        #1;
    endtask

    task automatic dropRequest(input int p);
        applyStimulus(p, 4'h0, cur_addr[p], cur_data[p], 1'b0, 1'b0, 1'b0);
    endtask

    task automatic randomReq(input int p);
        applyStimulus(p, 4'($urandom_range(1, 7)), 18'(18'h100 + $urandom_range(0, 7)),
                      16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
    endtask

    task automatic preload(input logic [AB-1:0] addr, input logic [15:0] wdata);
        preload_addr = addr;
        preload_data = wdata;
        preload_en   = 1'b1;
        ref_mem[addr] = wdata;
        @(negedge clk);
        #1;
        preload_en = 1'b0;
    endtask

    // Checks the ack cycle of port p and advances the shadow memory.
    task automatic checkAck(input int p, input string name);
        logic [15:0] expw;
        checkOutput({name, " ack"}, 32'(ackOf(p)), 32'(cur_tag[p]));
        checkOutput({name, " stall"}, 32'(stallOf(p)), 32'(0));
        checkOutput({name, " other ack"}, 32'(ackOf(1 - p)), 32'(0));
        checkOutput({name, " ack pins"}, 32'(pins()), 32'(IDLE_PINS));
        if (cur_we[p]) begin
            expw = ref_mem[cur_addr[p]];
            if (cur_ub[p]) expw[15:8] = cur_data[p][15:8];
            if (cur_lb[p]) expw[7:0]  = cur_data[p][7:0];
            ref_mem[cur_addr[p]] = expw;
        end else begin
            checkOutput({name, " data"}, 32'(data), 32'(ref_mem[cur_addr[p]]));
        end
    endtask

    // Full single-word transaction of port p, already applied in an IDLE cycle
    // with the bus free: ACCESS in cycles 1..ACC, ack in cycle ACC+1.
    task automatic runSingle(input int p, input string name);
        checkOutput({name, " c0 stall"}, 32'(stallOf(p)), 32'(1));
        checkOutput({name, " c0 pins"}, 32'(pins()), 32'(IDLE_PINS));
        for (int k = 1; k <= ACC; k++) begin
            step();
            checkOutput({name, " pins"}, 32'(pins()), 32'(accessPins(p, k)));
            checkOutput({name, " addr"}, 32'(sram_addr), 32'(cur_addr[p]));
            checkOutput({name, " access stall"}, 32'(stallOf(p)), 32'(1));
            checkOutput({name, " access ack"}, 32'(ackOf(p)), 32'(0));
            if (cur_we[p]) begin
                checkOutput({name, " dout"}, 32'(sram_dout), 32'(cur_data[p]));
            end
        end
        step();
        checkAck(p, name);
        step();
        dropRequest(p);
        checkOutput({name, " idle stall"}, 32'(stallOf(p)), 32'(0));
        checkOutput({name, " idle ack"}, 32'(ackOf(p)), 32'(0));
    endtask

    // Waits (bounded) for an ack on port p; the other port must stay unacked
    // and stalled exactly when it requests.
    task automatic waitAck(input int p, input string name, output int cycles);
        cycles = 0;
        while (ackOf(p) == 4'h0 && cycles < 40) begin
            checkOutput({name, " other ack"}, 32'(ackOf(1 - p)), 32'(0));
            checkOutput({name, " other stall"}, 32'(stallOf(1 - p)), 32'(reqOf(1 - p) != 4'h0));
            step();
            cycles++;
        end
        checkOutput({name, " timeout"}, 32'(cycles < 40), 32'(1));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        preload_en  = 1'b0;
        preload_addr = '0;
        preload_data = '0;
        reset_n = 1'b0;
        for (int p = 0; p < 2; p++) begin
            cur_tag[p] = '0; cur_addr[p] = '0; cur_data[p] = '0;
            cur_we[p] = 1'b0; cur_ub[p] = 1'b0; cur_lb[p] = 1'b0;
        end
        p0_request = '0; p0_addr = '0; p0_data = '0; p0_we = 1'b0; p0_ub = 1'b0; p0_lb = 1'b0;
        p1_request = '0; p1_addr = '0; p1_data = '0; p1_we = 1'b0; p1_ub = 1'b0; p1_lb = 1'b0;
        #1;

        // Reset values
        checkOutput("rst pins", 32'(pins()), 32'(IDLE_PINS));
        checkOutput("rst addr", 32'(sram_addr), 32'(0));
        checkOutput("rst dout", 32'(sram_dout), 32'(0));
        checkOutput("rst data", 32'(data), 32'(0));
        checkOutput("rst acks", 32'({p0_ack, p1_ack}), 32'(0));
        checkOutput("rst stalls", 32'({p0_stall, p1_stall}), 32'(0));

        preload(18'h00010, 16'hBEEF);
        preload(18'h3FFFF, 16'h1234);
        for (int i = 0; i < 8; i++) begin
            preload(18'(18'h100 + i), 16'($urandom));
        end
        step();
        reset_n = 1'b1;
        step();

        // Port 0 read of a known word
        applyStimulus(0, 4'h3, 18'h00010, 16'h0000, 1'b0, 1'b1, 1'b1);
        runSingle(0, "p0 read");

        // Port 1 upper-byte write at the top address, then read it back
        applyStimulus(1, 4'h1, 18'h3FFFF, 16'hA55A, 1'b1, 1'b1, 1'b0);
        runSingle(1, "p1 write");
        applyStimulus(0, 4'h2, 18'h3FFFF, 16'h0000, 1'b0, 1'b1, 1'b1);
        runSingle(0, "p0 readback");

        // Port 0 three-word burst while port 1 requests throughout
        applyStimulus(0, 4'hB, 18'h100, 16'h0000, 1'b0, 1'b1, 1'b1);
        step();
        applyStimulus(1, 4'h5, 18'h101, 16'h0000, 1'b0, 1'b1, 1'b1);
        waitAck(0, "burst w0", n);
        checkOutput("burst w0 latency", 32'(n), 32'(ACC));
        checkAck(0, "burst w0");
        step();
        applyStimulus(0, 4'hC, 18'h102, 16'h3C3C, 1'b1, 1'b1, 1'b1);
        waitAck(0, "burst w1", n);
        checkOutput("burst w1 spacing", 32'(n), 32'(ACC + 1));
        checkAck(0, "burst w1");
        step();
        applyStimulus(0, 4'h6, 18'h102, 16'h0000, 1'b0, 1'b1, 1'b1);
        waitAck(0, "burst w2", n);
        checkOutput("burst w2 spacing", 32'(n), 32'(ACC + 1));
        checkAck(0, "burst w2");
        step();
        dropRequest(0);
        waitAck(1, "after burst", n);
        checkOutput("after burst latency", 32'(n), 32'(ACC + 1));
        checkAck(1, "after burst");
        step();
        dropRequest(1);

        // Locked port drops its request: one lock-release cycle, then port 1
        applyStimulus(0, 4'hB, 18'h103, 16'h0000, 1'b0, 1'b1, 1'b1);
        step();
        applyStimulus(1, 4'h4, 18'h104, 16'h0000, 1'b0, 1'b1, 1'b1);
        waitAck(0, "lock w0", n);
        checkAck(0, "lock w0");
        step();
        dropRequest(0);
        checkOutput("lock release pins", 32'(pins()), 32'(IDLE_PINS));
        waitAck(1, "lock release", n);
        checkOutput("lock release latency", 32'(n), 32'(ACC + 2));
        checkAck(1, "lock release");
        step();
        dropRequest(1);

        // Reset in the middle of a write: bus released at once, write lost
        applyStimulus(0, 4'h7, 18'h105, 16'h5AA5, 1'b1, 1'b1, 1'b1);
        step();
        checkOutput("pre-reset pins", 32'(pins()), 32'(accessPins(0, 1)));
        reset_n = 1'b0;
        #1;
        checkOutput("mid rst pins", 32'(pins()), 32'(IDLE_PINS));
        checkOutput("mid rst addr", 32'(sram_addr), 32'(0));
        checkOutput("mid rst dout", 32'(sram_dout), 32'(0));
        checkOutput("mid rst acks", 32'({p0_ack, p1_ack}), 32'(0));
        dropRequest(0);
        step();
        step();
        reset_n = 1'b1;
        step();

        // Both ports keep requesting: grants alternate from port 0. Port 0's
        // first request reads the word whose write was cut off by reset.
        applyStimulus(0, 4'h2, 18'h105, 16'h0000, 1'b0, 1'b1, 1'b1);
        randomReq(1);
        expect_port = 0;
        for (int g = 0; g < 6; g++) begin
            n = 0;
            while (p0_ack == 4'h0 && p1_ack == 4'h0 && n < 40) begin
                step();
                n++;
            end
            checkOutput("alt timeout", 32'(n < 40), 32'(1));
            checkOutput("alt winner", 32'(p1_ack != 4'h0), 32'(expect_port));
            checkOutput("alt loser stall", 32'(stallOf(1 - expect_port)), 32'(reqOf(1 - expect_port) != 4'h0));
            checkAck(expect_port, "alt");
            step();
            if (g < 4) begin
                randomReq(expect_port);
            end else begin
                dropRequest(expect_port);
            end
            expect_port = 1 - expect_port;
        end

        // Random single-word traffic from either port
        for (int i = 0; i < 24; i++) begin
            int p;
            p = int'($urandom_range(0, 1));
            randomReq(p);
            runSingle(p, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
